// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: one memory op in flight, issues a single-cycle pmem read or write request,
// aligns and extends read data, and returns every op (memory or not) to WBU in program order.
module ysyx_23060201_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_load,
  input  logic                  in_store,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_misalign,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [7:0]            mem_rmask,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic                  load_q, load_d;
  logic                  store_q, store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  misalign_q, misalign_d;

  logic                  in_mem;
  logic                  in_mis;
  logic [3:0]            mask;
  logic [DATA_WIDTH-1:0] rword;
  logic [DATA_WIDTH-1:0] ld_ext;

  // funct3[1:0]: 00 byte, 01 half, anything else behaves as a word access
  assign in_mem = in_load | in_store;
  always_comb begin
    in_mis = 1'b0;
    if (in_funct3[1:0] == 2'b01) in_mis = in_addr[0];
    else if (in_funct3[1])       in_mis = |in_addr[1:0];
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   mask = 4'b0001 << addr_q[1:0];
      2'b01:   mask = 4'b0011 << addr_q[1:0];
      default: mask = 4'b1111;
    endcase
  end

  assign rword = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  ld_ext = {{24{rword[7]}},  rword[7:0]};
      3'b100:  ld_ext = {24'b0,           rword[7:0]};
      3'b001:  ld_ext = {{16{rword[15]}}, rword[15:0]};
      3'b101:  ld_ext = {16'b0,           rword[15:0]};
      default: ld_ext = rword;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    store_d    = store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_d   = in_load;
          store_d  = in_store;
          funct3_d = in_funct3;
          addr_d   = in_addr;
          wdata_d  = in_wdata;
          if (in_mem && in_mis) begin
            misalign_d = 1'b1;
            data_d     = '0;
            state_d    = DONE;
          end else if (in_mem) begin
            state_d = REQ;
          end else begin
            data_d  = DATA_WIDTH'(in_addr);
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (load_q) begin
          state_d = WAIT;
        end else begin
          data_d  = '0;
          state_d = DONE;
        end
      end
      WAIT: begin
        data_d  = ld_ext;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          misalign_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      store_q    <= store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      misalign_q <= misalign_d;
    end
  end

  // every output decodes registered state only, so no combinational in_* -> out path
  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_data     = data_q;
  assign out_misalign = misalign_q;

  assign mem_ren   = (state_q == REQ) && load_q;
  assign mem_wen   = (state_q == REQ) && store_q;
  assign mem_raddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_waddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_rmask = {4'b0000, mask};
  assign mem_wmask = {4'b0000, mask};
  assign mem_wdata = wdata_q << {addr_q[1:0], 3'b000};

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Bench for the LSU: directed vector table, randomized ops against a byte-level memory model,
// and an asynchronous reset in the middle of a store.
module tb_ysyx_23060201_lsu;

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_load, in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_misalign;
  logic [31:0] out_data;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_raddr, mem_waddr, mem_rdata, mem_wdata;
  logic [7:0]  mem_rmask, mem_wmask;

  logic [31:0] mem_model [16];
  int n_cmp = 0;
  int n_err = 0;

  ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_misalign(out_misalign),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rmask(mem_rmask), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered-read memory: word appears the cycle after ren is sampled, 0 otherwise
  always @(posedge clk) mem_rdata <= mem_ren ? mem_model[mem_raddr[5:2]] : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, word, data;
    logic        mis;
    int          lat;
    logic [3:0]  mask;
    logic [31:0] wd;
    int          rdy;
  } vec_t;

  vec_t tbl [15];

  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input int rdy,
                        input logic [31:0] e_data, input logic e_mis, input int e_lat,
                        input logic [3:0] e_mask, input logic [31:0] e_wd);
    int nren, nwen, lat;
    logic got;
    logic [31:0] ra, wa, wd;
    logic [7:0]  rm, wm;
    nren = 0; nwen = 0; lat = 0; got = 1'b0;
    ra = '0; wa = '0; wd = '0; rm = '0; wm = '0;
    @(negedge clk);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_load = ld; in_store = st; in_funct3 = f3; in_addr = addr; in_wdata = wdata;
    @(posedge clk);
    #1 in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_addr = $urandom; in_wdata = $urandom;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (mem_ren) begin nren++; ra = mem_raddr; rm = mem_rmask; end
      if (mem_wen) begin nwen++; wa = mem_waddr; wm = mem_wmask; wd = mem_wdata; end
      if (out_valid) begin got = 1'b1; lat = c; end
    end
    if (!got) chk("out_valid_timeout", 32'd0, 32'd1);
    chk("latency", lat, e_lat);
    chk("out_data", out_data, e_data);
    chk("out_misalign", {31'b0, out_misalign}, {31'b0, e_mis});
    chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
    chk("ren_count", nren, (ld && !e_mis) ? 1 : 0);
    chk("wen_count", nwen, (st && !e_mis) ? 1 : 0);
    if (ld && !e_mis) begin
      chk("raddr", ra, addr & 32'hFFFF_FFFC);
      chk("rmask", {24'b0, rm}, {28'b0, e_mask});
    end
    if (st && !e_mis) begin
      chk("waddr", wa, addr & 32'hFFFF_FFFC);
      chk("wmask", {24'b0, wm}, {28'b0, e_mask});
      chk("wdata", wd, e_wd);
    end
    for (int k = 0; k < rdy; k++) begin
      @(negedge clk);
      chk("hold_data", out_data, e_data);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("post_valid", {31'b0, out_valid}, 32'd0);
    chk("post_in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_misalign", {31'b0, out_misalign}, 32'd0);
    if (st && !e_mis)
      for (int b = 0; b < 4; b++)
        if (e_mask[b]) mem_model[addr[5:2]][8*b +: 8] = e_wd[8*b +: 8];
  endtask

  // spec-level reference: access size from funct3, byte offset arithmetic, explicit extension
  task automatic rand_op();
    logic ld, st, mis;
    logic [2:0] f3;
    logic [31:0] addr, wdata, word, val, e_data, e_wd;
    logic [3:0] e_mask;
    int size, off, lat, kind;
    logic [2:0] ld_f3 [8];
    logic [2:0] st_f3 [6];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    kind = $urandom_range(0, 2);
    ld = (kind == 0); st = (kind == 1);
    f3 = ld ? ld_f3[$urandom_range(0, 7)] : st ? st_f3[$urandom_range(0, 5)] : 3'($urandom);
    addr = st || ld ? (32'h8000_0000 | ($urandom & 32'h3F)) : $urandom;
    wdata = $urandom;
    off = int'(addr[1:0]);
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis = (ld || st) && ((size == 2 && (off % 2) != 0) || (size == 4 && off != 0));
    e_mask = (!(ld || st) || mis) ? 4'h0 : 4'(((1 << size) - 1) << off);
    e_wd = wdata << (8 * off);
    lat = (!(ld || st) || mis) ? 1 : st ? 2 : 3;
    e_data = 32'h0;
    if (!(ld || st)) e_data = addr;
    else if (ld && !mis) begin
      word = mem_model[addr[5:2]];
      val = word >> (8 * off);
      if (size == 1) begin
        e_data = val & 32'hFF;
        if (!f3[2] && e_data >= 32'd128) e_data = e_data - 32'd256;
      end else if (size == 2) begin
        e_data = val & 32'hFFFF;
        if (!f3[2] && e_data >= 32'd32768) e_data = e_data - 32'd65536;
      end else e_data = val;
    end
    run_op(ld, st, f3, addr, wdata, $urandom_range(0, 3), e_data, mis, lat, e_mask, e_wd);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_funct3 = '0;
    in_addr = '0; in_wdata = '0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;

    tbl[0]  = '{1'b1, 1'b0, 3'd2, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3, 4'hF, 32'h0, 0};
    tbl[1]  = '{1'b1, 1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 32'hFFFF_FF80, 1'b0, 3, 4'h8, 32'h0, 1};
    tbl[2]  = '{1'b1, 1'b0, 3'd4, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 32'h0000_0080, 1'b0, 3, 4'h8, 32'h0, 0};
    tbl[3]  = '{1'b0, 1'b1, 3'd1, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 32'h0, 1'b0, 2, 4'hC, 32'hABCD_0000, 0};
    tbl[4]  = '{1'b1, 1'b0, 3'd2, 32'h8000_0001, 32'h0, 32'h0, 32'h0, 1'b1, 1, 4'h0, 32'h0, 0};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 32'h0000_0042, 32'h0, 32'h0, 32'h0000_0042, 1'b0, 1, 4'h0, 32'h0, 5};
    tbl[6]  = '{1'b1, 1'b0, 3'd1, 32'h8000_0002, 32'h0, 32'h80AA_BBCC, 32'hFFFF_80AA, 1'b0, 3, 4'hC, 32'h0, 0};
    tbl[7]  = '{1'b1, 1'b0, 3'd5, 32'h8000_0002, 32'h0, 32'h80AA_BBCC, 32'h0000_80AA, 1'b0, 3, 4'hC, 32'h0, 2};
    tbl[8]  = '{1'b1, 1'b0, 3'd1, 32'h8000_0001, 32'h0, 32'h0, 32'h0, 1'b1, 1, 4'h0, 32'h0, 0};
    tbl[9]  = '{1'b0, 1'b1, 3'd2, 32'h8000_0003, 32'h55, 32'h0, 32'h0, 1'b1, 1, 4'h0, 32'h0, 1};
    tbl[10] = '{1'b0, 1'b1, 3'd0, 32'h8000_0001, 32'hEE, 32'h0, 32'h0, 1'b0, 2, 4'h2, 32'h0000_EE00, 0};
    tbl[11] = '{1'b1, 1'b0, 3'd7, 32'h8000_0008, 32'h0, 32'h1122_3344, 32'h1122_3344, 1'b0, 3, 4'hF, 32'h0, 0};
    tbl[12] = '{1'b1, 1'b0, 3'd0, 32'h8000_0000, 32'h0, 32'h0000_007F, 32'h0000_007F, 1'b0, 3, 4'h1, 32'h0, 0};
    tbl[13] = '{1'b0, 1'b1, 3'd2, 32'h8000_0008, 32'hCAFE_BABE, 32'h0, 32'h0, 1'b0, 2, 4'hF, 32'hCAFE_BABE, 1};
    tbl[14] = '{1'b1, 1'b0, 3'd5, 32'h8000_0001, 32'h0, 32'h0, 32'h0, 1'b1, 1, 4'h0, 32'h0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_misalign", {31'b0, out_misalign}, 32'd0);
    chk("rst_ren_wen", {30'b0, mem_ren, mem_wen}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      mem_model[tbl[i].addr[5:2]] = tbl[i].word;
      run_op(tbl[i].ld, tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rdy,
             tbl[i].data, tbl[i].mis, tbl[i].lat, tbl[i].mask, tbl[i].wd);
    end

    for (int i = 0; i < 80; i++) rand_op();

    // async reset while a store sits in REQ
    @(negedge clk);
    in_valid = 1'b1; in_store = 1'b1; in_funct3 = 3'd2; in_addr = 32'h8000_0010; in_wdata = 32'h5A5A_5A5A;
    @(posedge clk);
    #1 in_valid = 1'b0; in_store = 1'b0;
    @(negedge clk);
    chk("rst_mid_wen_before", {31'b0, mem_wen}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_wen_drop", {31'b0, mem_wen}, 32'd0);
    chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rel_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_rel_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_rel_out_data", out_data, 32'h0);
    run_op(1'b0, 1'b0, 3'd0, 32'h0000_0007, 32'h0, 0, 32'h0000_0007, 1'b0, 1, 4'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
